// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and result-register geometry.
package mac_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam int RES_BASE   = 2;
    localparam int RES_ADDR_W = 4;
    localparam int RES_DATA_W = 16;

endpackage

// File: rtl/mac_datapath.sv
// Unsigned multiply-accumulate: zero-extended product added into a wrapping accumulator.
module mac_datapath #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_sum
);

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    r_acc;

    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

    // o_sum is the value the accumulator takes on an enabled edge, so the
    // sequencer can capture the final dot product in the same cycle.
    assign o_sum = r_acc + ACC_W'(w_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Sequences NUM_RESULTS dot products over a synchronous operand memory and writes each
// result into the downstream result register (mac_en=1, wr=0, address=RES_BASE+index).
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int VEC_LEN     = 4,
    parameter int NUM_RESULTS = 8,
    parameter int RES_BASE    = mac_pkg::RES_BASE,
    parameter int ADDR_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  op_rd,
    output logic [ADDR_W-1:0]     op_addr,
    input  logic [DATA_W-1:0]     a_data,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  res_mac_en,
    output logic                  res_wr,
    output logic [RES_ADDR_W-1:0] res_address,
    output logic [ACC_W-1:0]      res_din
);

    localparam int R_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
    localparam int E_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    state_t                r_state;
    state_t                w_next;
    logic [R_W-1:0]        r_row;
    logic [E_W-1:0]        r_elem;
    logic [RES_ADDR_W-1:0] r_res_address;
    logic [ACC_W-1:0]      r_res_din;
    logic [ACC_W-1:0]      w_sum;
    logic                  w_clear;
    logic                  w_acc_en;
    logic                  w_last_elem;
    logic                  w_last_row;

    assign w_last_elem = (r_elem == E_W'(VEC_LEN - 1));
    assign w_last_row  = (r_row == R_W'(NUM_RESULTS - 1));

    assign op_addr     = ADDR_W'(r_row) * ADDR_W'(VEC_LEN) + ADDR_W'(r_elem);
    assign res_wr      = 1'b0;
    assign res_address = r_res_address;
    assign res_din     = r_res_din;

    mac_datapath #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_en    (w_acc_en),
        .i_a     (a_data),
        .i_b     (b_data),
        .o_sum   (w_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        op_rd      = 1'b0;
        res_mac_en = 1'b0;
        w_clear    = 1'b0;
        w_acc_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next  = S_ISSUE;
                    w_clear = 1'b1;
                end
            end
            S_ISSUE: begin
                busy   = 1'b1;
                op_rd  = 1'b1;
                w_next = S_MAC;
            end
            S_MAC: begin
                busy     = 1'b1;
                w_acc_en = 1'b1;
                w_next   = w_last_elem ? S_WRITE : S_ISSUE;
            end
            S_WRITE: begin
                busy       = 1'b1;
                res_mac_en = 1'b1;
                w_clear    = 1'b1;
                w_next     = w_last_row ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The result is captured on the last MAC edge so it is already stable throughout WRITE;
    // address and data then hold until the next result overwrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row         <= '0;
            r_elem        <= '0;
            r_res_address <= '0;
            r_res_din     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row  <= '0;
                        r_elem <= '0;
                    end
                end
                S_MAC: begin
                    if (w_last_elem) begin
                        r_res_din     <= w_sum;
                        r_res_address <= RES_ADDR_W'(RES_BASE) + RES_ADDR_W'(r_row);
                    end else begin
                        r_elem <= r_elem + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!w_last_row) begin
                        r_row  <= r_row + 1'b1;
                        r_elem <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with an operand memory model and a result register model.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        op_rd;
    logic [4:0]  op_addr;
    logic [7:0]  a_data;
    logic [7:0]  b_data;
    logic        res_mac_en;
    logic        res_wr;
    logic [3:0]  res_address;
    logic [15:0] res_din;

    int nChecks = 0;
    int nFail   = 0;

    logic [7:0]  memA [32];
    logic [7:0]  memB [32];
    logic [15:0] resReg [16];
    logic [3:0]  wrAddrQ [$];
    logic [15:0] wrDataQ [$];
    logic [4:0]  opAddrQ [$];
    int          writeCount = 0;
    int          doneCount  = 0;
    int          longWrite  = 0;
    int          wrBad      = 0;
    logic        prevMacEn  = 1'b0;

    mac_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .op_rd       (op_rd),
        .op_addr     (op_addr),
        .a_data      (a_data),
        .b_data      (b_data),
        .res_mac_en  (res_mac_en),
        .res_wr      (res_wr),
        .res_address (res_address),
        .res_din     (res_din)
    );

    always #5 clk = ~clk;

    // Synchronous-read operand memory: data appears the cycle after op_rd.
    always @(posedge clk) begin
        if (op_rd) begin
            a_data <= memA[op_addr];
            b_data <= memB[op_addr];
        end
    end

    // Result register model plus write/done/op-address logging.
    always @(posedge clk) begin
        if (res_mac_en) begin
            if (res_wr !== 1'b0) wrBad++;
            else resReg[res_address] = res_din;
            if (prevMacEn) longWrite++;
            wrAddrQ.push_back(res_address);
            wrDataQ.push_back(res_din);
            writeCount++;
        end
        prevMacEn = res_mac_en;
        if (done) doneCount++;
        if (op_rd) opAddrQ.push_back(op_addr);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        logic [29:0] packed_outs;
        packed_outs = {busy, done, op_rd, op_addr, res_mac_en, res_wr, res_address, res_din};
        checkOutput(tag, {2'b00, packed_outs}, 32'h0);
    endtask

    // Starts a run and counts edges from the accept edge until done is seen.
    // pulseAt re-pulses start in that cycle; rstAt asserts rst mid-cycle and aborts the run.
    task automatic applyStimulus(input int pulseAt, input int rstAt, output int latency);
        int cyc;
        latency = -1;
        wrAddrQ.delete();
        wrDataQ.delete();
        opAddrQ.delete();
        writeCount = 0;
        doneCount  = 0;
        longWrite  = 0;
        wrBad      = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 200) begin
            if (done === 1'b1) begin
                latency = cyc;
                break;
            end
            if (cyc == rstAt) begin
                rst = 1'b1;
                #1;
                checkIdle("rst_mid_run_outputs");
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                latency = 0;
                break;
            end
            start = (cyc == pulseAt);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Steps past the DONE cycle and confirms a single done pulse and idle state.
    task automatic finishRun(input string tag);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_cleared"}, done, 1'b0);
        checkOutput({tag, "_busy_cleared"}, busy, 1'b0);
        checkOutput({tag, "_done_count"}, doneCount, 1);
        checkOutput({tag, "_write_count"}, writeCount, 8);
        checkOutput({tag, "_single_cycle_writes"}, longWrite, 0);
        checkOutput({tag, "_wr_low"}, wrBad, 0);
    endtask

    initial begin
        int lat;
        int errs;
        logic [15:0] expVal;

        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) resReg[i] = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkIdle("reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkIdle("idle_after_reset");

        // All ones: 8 writes of 4 to addresses 2..9, done 73 cycles after start
        for (int k = 0; k < 32; k++) begin
            memA[k] = 8'd1;
            memB[k] = 8'd1;
        end
        applyStimulus(-1, -1, lat);
        checkOutput("ones_latency", lat, 73);
        finishRun("ones");
        errs = 0;
        for (int r = 0; r < 8; r++) begin
            if (wrAddrQ[r] !== 4'(r + 2)) errs++;
            if (wrDataQ[r] !== 16'h0004) errs++;
        end
        checkOutput("ones_write_sequence", errs, 0);
        errs = 0;
        for (int k = 0; k < 32; k++) if (opAddrQ[k] !== 5'(k)) errs++;
        checkOutput("ones_op_addr_sequence", errs, 0);
        checkOutput("ones_op_read_count", opAddrQ.size(), 32);
        checkOutput("hold_res_address", res_address, 4'd9);
        checkOutput("hold_res_din", res_din, 16'h0004);

        // All 255: 4*65025 wraps to 0xF804
        for (int k = 0; k < 32; k++) begin
            memA[k] = 8'hFF;
            memB[k] = 8'hFF;
        end
        applyStimulus(-1, -1, lat);
        checkOutput("max_latency", lat, 73);
        finishRun("max");
        for (int r = 0; r < 8; r++) checkOutput($sformatf("max_result_%0d", r), resReg[r + 2], 16'hF804);

        // Pair k holds a=k, b=1: result r = 4r+(4r+1)+(4r+2)+(4r+3) = 16r+6
        for (int k = 0; k < 32; k++) begin
            memA[k] = 8'(k);
            memB[k] = 8'd1;
        end
        applyStimulus(-1, -1, lat);
        checkOutput("ramp_latency", lat, 73);
        finishRun("ramp");
        checkOutput("ramp_result_first", resReg[2], 16'h0006);
        checkOutput("ramp_result_last", resReg[9], 16'h0076);
        for (int r = 1; r < 7; r++) begin
            expVal = 16'(16 * r + 6);
            checkOutput($sformatf("ramp_result_%0d", r), resReg[r + 2], expVal);
        end

        // start pulsed again mid-run is ignored
        applyStimulus(10, -1, lat);
        checkOutput("repulse_latency", lat, 73);
        finishRun("repulse");
        repeat (3) @(negedge clk);
        checkOutput("repulse_no_second_run", busy, 1'b0);

        // Reset during result 2: results 0 and 1 written, partial result never written
        for (int k = 0; k < 32; k++) begin
            memA[k] = 8'd2;
            memB[k] = 8'd3;
        end
        applyStimulus(-1, 20, lat);
        repeat (10) @(negedge clk);
        checkIdle("idle_after_mid_run_reset");
        checkOutput("rst_writes_before_abort", writeCount, 2);
        checkOutput("rst_result0_kept", resReg[2], 16'h0018);
        checkOutput("rst_result1_kept", resReg[3], 16'h0018);
        checkOutput("rst_partial_not_written", resReg[4], 16'h0026);

        // Fresh run after reset starts from operand 0 and address 2
        applyStimulus(-1, -1, lat);
        checkOutput("restart_latency", lat, 73);
        finishRun("restart");
        checkOutput("restart_first_op_addr", opAddrQ[0], 5'd0);
        checkOutput("restart_first_address", wrAddrQ[0], 4'd2);
        errs = 0;
        for (int r = 0; r < 8; r++) if (resReg[r + 2] !== 16'h0018) errs++;
        checkOutput("restart_readback", errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
